// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one partial-product step per cycle.
// start loads the operands; WIDTH steps follow. done is high during the
// cycle whose closing edge is the final step, and prod carries the complete
// product during that cycle so the caller can capture it on that edge.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int unsigned    SHW  = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] step_sum;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     cnt_q;
    logic               busy_q;

    // Accumulator plus the current partial product.
    always_comb begin
        step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == LAST);
    assign prod = step_sum;

    // Operand load on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= step_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU. Ops 0..6 complete on the accept edge; MUL runs
// the iterative multiplier for WIDTH cycles. Results sit in a single output
// register that is refilled on the same edge it is drained.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             zero
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e             state_q;
    state_e             state_d;
    logic               accept;
    logic               load_alu;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [SHW-1:0]     sh_amt;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic [WIDTH-1:0]   out_q;
    logic               cout_q;
    logic               zero_q;
    logic               valid_q;

    assign in_ready  = (state_q == ST_IDLE) && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign load_alu  = accept && (op != OP_MUL);
    assign sh_amt    = b[SHW-1:0];

    // One extra bit catches carry/borrow; shifts park the bit shifted out there.
    assign add_w = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_w = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    assign shl_w = {1'b0, a} << sh_amt;
    assign shr_w = {a, 1'b0} >> sh_amt;

    // Single-cycle result for ops 0..6.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        unique case (op)
            OP_ADD: {res_c, res} = add_w;
            OP_SUB: begin
                res   = sub_w[WIDTH-1:0];
                res_c = sub_w[WIDTH];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: {res_c, res} = shl_w;
            OP_SHR: {res, res_c} = shr_w;
            OP_MUL: res = '0;
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // FSM next state: park in ST_MUL until the multiplier reports done.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (mul_done)  state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register: load on ALU accept or multiply completion, else drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_alu) begin
            out_q   <= res;
            cout_q  <= res_c;
            zero_q  <= (res == '0);
            valid_q <= 1'b1;
        end else if (mul_done) begin
            out_q   <= mul_prod[WIDTH-1:0];
            cout_q  <= |mul_prod[2*WIDTH-1:WIDTH];
            zero_q  <= (mul_prod[WIDTH-1:0] == '0);
            valid_q <= 1'b1;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out       = out_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=32. Expected results are
// queued on accept by a plain-arithmetic model; monitors pop and compare on
// every output transfer.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, zero8;
    logic [7:0] a8, b8, out8;
    logic [2:0] op8;

    logic        in_valid32, in_ready32, cin32, out_valid32, out_ready32, cout32, zero32;
    logic [31:0] a32, b32, out32;
    logic [2:0]  op32;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode8 = 1;
    int rdy_mode32 = 1;

    // Expected entries: [65] zero, [64] cout, [63:0] out.
    logic [65:0] q8[$];
    logic [65:0] q32[$];

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .op(op8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out(out8), .cout(cout8), .zero(zero8)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32), .op(op32), .out_valid(out_valid32),
        .out_ready(out_ready32), .out(out32), .cout(cout32), .zero(zero32)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [65:0] pack(longint unsigned o, logic c);
        return {(o == 0), c, o};
    endfunction

    // Reference behaviour straight from the op definitions.
    function automatic logic [65:0] model(int w, logic [2:0] op, longint unsigned a,
                                          longint unsigned b, logic cin);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned r;
        longint unsigned p;
        logic c = 1'b0;
        int sh = int'(b % longint'(w));
        case (op)
            3'd0: begin r = a + b + cin; c = ((r >> w) & 1) != 0; end
            3'd1: begin r = a - b - cin; c = (a < b + cin); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = a << sh; c = (sh != 0) && (((a >> (w - sh)) & 1) != 0); end
            3'd6: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
            default: begin p = a * b; r = p; c = (p >> w) != 0; end
        endcase
        return pack(r & mask, c);
    endfunction

    task automatic check(string name, logic [65:0] act, logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got zero=%0b cout=%0b out=%h, want zero=%0b cout=%0b out=%h",
                     name, act[65], act[64], act[63:0], exp[65], exp[64], exp[63:0]);
        end
    endtask

    task automatic check_val(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, got no handshake want handshake", name);
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send8(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic cin,
                         bit use_exp, logic [65:0] exp);
        int waitc = 0;
        bit ok = 1'b1;
        op8 = op; a8 = a; b8 = b; cin8 = cin; in_valid8 = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready8) break;
            waitc++;
            if (waitc > 200) begin ok = 1'b0; timeout_fail("send8"); break; end
        end
        if (ok) q8.push_back(use_exp ? exp : model(8, op, a, b, cin));
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic send32(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic cin);
        int waitc = 0;
        bit ok = 1'b1;
        op32 = op; a32 = a; b32 = b; cin32 = cin; in_valid32 = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready32) break;
            waitc++;
            if (waitc > 400) begin ok = 1'b0; timeout_fail("send32"); break; end
        end
        if (ok) q32.push_back(model(32, op, a, b, cin));
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 1000) begin @(posedge clk); n++; end
        if (q8.size() != 0) timeout_fail("drain8");
        #1;
    endtask

    task automatic drain32();
        int n = 0;
        while (q32.size() != 0 && n < 1000) begin @(posedge clk); n++; end
        if (q32.size() != 0) timeout_fail("drain32");
        #1;
    endtask

    // out_ready drivers, updated mid-cycle so mode changes land before sampling.
    initial begin
        out_ready8 = 1'b1;
        out_ready32 = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready8  = (rdy_mode8 == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode8 == 1);
            out_ready32 = (rdy_mode32 == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode32 == 1);
        end
    end

    // Monitors: compare on each output transfer.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && out_valid8 && out_ready8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb8: got unexpected result out=%h want none", out8);
            end else begin
                check("sb8", {zero8, cout8, 56'd0, out8}, q8.pop_front());
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && out_valid32 && out_ready32) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb32: got unexpected result out=%h want none", out32);
            end else begin
                check("sb32", {zero32, cout32, 32'd0, out32}, q32.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b_list[12] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h55, 8'h5A,
                                   8'h7F, 8'h80, 8'h81, 8'hA5, 8'hFE, 8'hFF};
        int k;
        int c0;
        bit ok_ir;
        bit seen;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; op8 = 0;
        in_valid32 = 0; a32 = 0; b32 = 0; cin32 = 0; op32 = 0;
        #12;
        check("reset8", {zero8, cout8, 56'd0, out8}, 66'd0);
        check_val("reset8_out_valid", out_valid8, 0);
        check("reset32", {zero32, cout32, 32'd0, out32}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("reset8_in_ready", in_ready8, 1);
        @(posedge clk);
        #1;

        // Directed cases with hand-derived results.
        send8(3'd0, 8'hFF, 8'h01, 1'b1, 1, pack(64'h01, 1'b1));
        send8(3'd1, 8'h00, 8'h01, 1'b0, 1, pack(64'hFF, 1'b1));
        send8(3'd1, 8'h5A, 8'h5A, 1'b0, 1, pack(64'h00, 1'b0));
        send8(3'd5, 8'h81, 8'h01, 1'b0, 1, pack(64'h02, 1'b1));
        send8(3'd6, 8'h81, 8'h09, 1'b0, 1, pack(64'h40, 1'b1));
        send8(3'd5, 8'hA5, 8'h00, 1'b0, 1, pack(64'hA5, 1'b0));
        send8(3'd6, 8'h3C, 8'h08, 1'b0, 1, pack(64'h3C, 1'b0));
        send8(3'd4, 8'hF0, 8'h3C, 1'b1, 1, pack(64'hCC, 1'b0));
        send8(3'd7, 8'h10, 8'h10, 1'b0, 1, pack(64'h00, 1'b1));
        k = 0;
        ok_ir = 1'b1;
        while (k < 40) begin
            @(negedge clk);
            if (out_valid8) break;
            if (in_ready8) ok_ir = 1'b0;
            @(posedge clk);
            k++;
        end
        check_val("mul_latency", k, 8);
        check_val("mul_in_ready_low", ok_ir, 1);
        @(posedge clk);
        #1;
        send8(3'd7, 8'h03, 8'h05, 1'b0, 1, pack(64'h0F, 1'b0));
        drain8();

        // Backpressure: result must hold and a second input must wait.
        rdy_mode8 = 0;
        send8(3'd0, 8'h12, 8'h34, 1'b0, 1, pack(64'h46, 1'b0));
        op8 = 3'd0; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; in_valid8 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("bp_out_stable", out8, 'h46);
            check_val("bp_in_ready_low", in_ready8, 0);
        end
        @(posedge clk);
        #1;
        rdy_mode8 = 1;
        send8(3'd0, 8'h01, 8'h02, 1'b0, 1, pack(64'h03, 1'b0));
        c0 = cyc;
        for (int i = 0; i < 8; i++) send8(3'd0, 8'(i * 37), 8'(i + 200), 1'(i), 0, '0);
        check_val("stream_rate", cyc - c0, 8);
        drain8();

        // Reset with a result pending.
        rdy_mode8 = 0;
        send8(3'd0, 8'h20, 8'h22, 1'b0, 1, pack(64'h42, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        #1;
        check("rst_mid_outputs", {zero8, cout8, 56'd0, out8}, 66'd0);
        check_val("rst_mid_out_valid", out_valid8, 0);
        rdy_mode8 = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_mid_in_ready", in_ready8, 1);
        @(posedge clk);
        #1;

        // Reset at the third multiply iteration: nothing may emerge.
        send8(3'd7, 8'h07, 8'h09, 1'b0, 0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        #2;
        check_val("rst_mul_out_valid", out_valid8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid8) seen = 1'b1;
        end
        check_val("rst_mul_no_result", seen, 0);
        @(posedge clk);
        #1;

        // Ops 0..3: every a and cin against a spread of b values.
        for (int o = 0; o < 4; o++)
            for (int j = 0; j < 12; j++)
                for (int x = 0; x < 256; x++)
                    for (int c = 0; c < 2; c++)
                        send8(3'(o), 8'(x), b_list[j], 1'(c), 0, '0);
        drain8();

        // Random stream, WIDTH=8.
        rdy_mode8 = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
            send8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 0, '0);
        end
        rdy_mode8 = 1;
        drain8();

        // Random stream, WIDTH=32.
        rdy_mode32 = 2;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb = 32'(ra + 32'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_FFFF;
            send32(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
        end
        rdy_mode32 = 1;
        drain32();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
